// File: rtl/pe_lane_serializer_if.sv
// Handshake bundle for pe_lane_serializer: vector/command input side and lane-beat output side.
// The out_parity member exists only when PE_SER_PARITY_EN is defined.
interface pe_lane_serializer_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LANES = 32,
    parameter int unsigned SEL_W = $clog2(LANES)
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH*LANES-1:0] in_data;
    logic [1:0]             mode;
    logic [SEL_W-1:0]       sel;
    logic [SEL_W:0]         count;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_data;
    logic [SEL_W-1:0]       out_lane;
    logic                   out_last;
    logic                   busy;
`ifdef PE_SER_PARITY_EN
    logic                   out_parity;

    modport master (
        output in_valid, in_data, mode, sel, count, out_ready,
        input  in_ready, out_valid, out_data, out_lane, out_last, busy, out_parity
    );

    modport slave (
        input  in_valid, in_data, mode, sel, count, out_ready,
        output in_ready, out_valid, out_data, out_lane, out_last, busy, out_parity
    );
`else
    modport master (
        output in_valid, in_data, mode, sel, count, out_ready,
        input  in_ready, out_valid, out_data, out_lane, out_last, busy
    );

    modport slave (
        input  in_valid, in_data, mode, sel, count, out_ready,
        output in_ready, out_valid, out_data, out_lane, out_last, busy
    );
`endif
endinterface

// File: rtl/pe_lane_serializer.sv
// Captures a LANES x WIDTH vector and emits one selected lane or a wrapping scan of lanes,
// one registered beat per handshake. Optional feature macro: PE_SER_PARITY_EN (out_parity).
module pe_lane_serializer #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned LANES       = 32,
    parameter int unsigned SEL_W       = $clog2(LANES),
    parameter bit          REVERSE_SEL = 1'b1
) (
    input logic                 clk,
    input logic                 rst,
    pe_lane_serializer_if.slave bus
);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    localparam logic [SEL_W:0]   LanesExt   = (SEL_W+1)'(LANES);
    localparam logic [SEL_W-1:0] LanesTrunc = SEL_W'(LANES);
    localparam logic [SEL_W-1:0] LastIdx    = SEL_W'(LANES - 1);

    state_e                 r_state;
    logic [WIDTH*LANES-1:0] r_data;
    logic [1:0]             r_mode;
    logic [SEL_W-1:0]       r_cursor;
    logic [SEL_W:0]         r_remaining;
    logic                   r_out_valid;
    logic [WIDTH-1:0]       r_out_data;
    logic [SEL_W-1:0]       r_out_lane;
    logic                   r_out_last;
`ifdef PE_SER_PARITY_EN
    logic                   r_out_parity;
`endif

    logic                   w_in_ready;
    logic                   w_accept;
    logic                   w_fire;
    logic                   w_in_scan;
    logic                   w_sel_oor;
    logic [SEL_W-1:0]       w_acc_cursor;
    logic [SEL_W:0]         w_acc_remaining;
    logic                   w_acc_last;
    logic [WIDTH-1:0]       w_acc_word;
    logic [SEL_W-1:0]       w_next_cursor;
    logic [WIDTH-1:0]       w_adv_word;

    // Out-of-range logical indices read as zero; otherwise map logical index to physical lane.
    function automatic logic [WIDTH-1:0] lane_word(input logic [WIDTH*LANES-1:0] vec,
                                                   input logic [SEL_W-1:0]       idx);
        int unsigned phys;
        if ({1'b0, idx} >= LanesExt) begin
            return '0;
        end
        phys = REVERSE_SEL ? (LANES - 1 - int'(idx)) : int'(idx);
        return vec[WIDTH*phys +: WIDTH];
    endfunction

    assign w_in_ready = !rst && (r_state == StIdle || (r_out_valid && bus.out_ready && r_out_last));

    always_comb begin
        w_accept        = bus.in_valid && w_in_ready;
        w_fire          = r_out_valid && bus.out_ready;
        w_in_scan       = (bus.mode == 2'b01) || (bus.mode == 2'b10);
        w_sel_oor       = ({1'b0, bus.sel} >= LanesExt);
        w_acc_cursor    = bus.sel;
        // sel < 2^SEL_W < 2*LANES, so one subtraction is a full modulo reduction
        if (w_in_scan && w_sel_oor) begin
            w_acc_cursor = bus.sel - LanesTrunc;
        end
        w_acc_remaining = (SEL_W+1)'(1);
        if (w_in_scan) begin
            w_acc_remaining = (bus.count == '0) ? LanesExt : bus.count;
        end
        w_acc_last      = (w_acc_remaining == (SEL_W+1)'(1));
        w_acc_word      = lane_word(bus.in_data, w_acc_cursor);
    end

    always_comb begin
        w_next_cursor = r_cursor;
        if (r_mode == 2'b01) begin
            w_next_cursor = (r_cursor == LastIdx) ? '0 : r_cursor + 1'b1;
        end else if (r_mode == 2'b10) begin
            w_next_cursor = (r_cursor == '0) ? LastIdx : r_cursor - 1'b1;
        end
        w_adv_word = lane_word(r_data, w_next_cursor);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StIdle;
            r_data       <= '0;
            r_mode       <= 2'b00;
            r_cursor     <= '0;
            r_remaining  <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_lane   <= '0;
            r_out_last   <= 1'b0;
`ifdef PE_SER_PARITY_EN
            r_out_parity <= 1'b0;
`endif
        end else begin
            case (r_state)
                StIdle:  if (w_accept) r_state <= StSend;
                StSend:  if (w_fire && r_out_last && !w_accept) r_state <= StIdle;
                default: r_state <= StIdle;
            endcase

            if (w_accept) begin
                r_data       <= bus.in_data;
                r_mode       <= bus.mode;
                r_cursor     <= w_acc_cursor;
                r_remaining  <= w_acc_remaining;
                r_out_valid  <= 1'b1;
                r_out_data   <= w_acc_word;
                r_out_lane   <= w_acc_cursor;
                r_out_last   <= w_acc_last;
`ifdef PE_SER_PARITY_EN
                r_out_parity <= ^w_acc_word;
`endif
            end else if (w_fire && r_out_last) begin
                r_out_valid  <= 1'b0;
            end else if (w_fire) begin
                r_cursor     <= w_next_cursor;
                r_remaining  <= r_remaining - 1'b1;
                r_out_data   <= w_adv_word;
                r_out_lane   <= w_next_cursor;
                r_out_last   <= (r_remaining == (SEL_W+1)'(2));
`ifdef PE_SER_PARITY_EN
                r_out_parity <= ^w_adv_word;
`endif
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_lane  = r_out_lane;
    assign bus.out_last  = r_out_last;
    assign bus.busy      = (r_state == StSend);
`ifdef PE_SER_PARITY_EN
    assign bus.out_parity = r_out_parity;
`endif

endmodule

// File: tb/tb_pe_lane_serializer.sv
// Randomized bench for pe_lane_serializer against a lane-list reference model.
// Checks parity too when PE_SER_PARITY_EN is defined.
module tb_pe_lane_serializer;

    localparam int W  = 16;
    localparam int L  = 32;
    localparam int SW = 5;

    typedef struct {
        logic [SW-1:0] lane;
        logic [W-1:0]  data;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    logic rdy_rand;

    int n_vec  = 0;
    int n_err  = 0;
    int n_beat = 0;

    beat_t exp_q[$];

    pe_lane_serializer_if #(.WIDTH(W), .LANES(L)) sif ();

    pe_lane_serializer #(
        .WIDTH      (W),
        .LANES      (L),
        .REVERSE_SEL(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(sif)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: scoreboard pops on each output handshake, pushes a command's beats on accept.
    logic          prev_stall = 1'b0;
    logic [W-1:0]  prev_data;
    logic [SW-1:0] prev_lane;
    logic          prev_last;

    always @(negedge clk) begin
        beat_t e;
        int n, start, lane;
        logic direct;
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            check_eq("busy_vs_valid", sif.busy, sif.out_valid);
            if (prev_stall) begin
                check_eq("stall_valid", sif.out_valid, 1);
                check_eq("stall_data", sif.out_data, prev_data);
                check_eq("stall_lane", sif.out_lane, prev_lane);
                check_eq("stall_last", sif.out_last, prev_last);
            end
            if (sif.out_valid && sif.out_ready) begin
                n_beat++;
                if (exp_q.size() == 0) begin
                    check_eq("spurious_beat", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("beat_data", sif.out_data, e.data);
                    check_eq("beat_lane", sif.out_lane, e.lane);
                    check_eq("beat_last", sif.out_last, e.last);
`ifdef PE_SER_PARITY_EN
                    check_eq("beat_parity", sif.out_parity, ^e.data);
`endif
                end
            end
            prev_stall = sif.out_valid && !sif.out_ready;
            prev_data  = sif.out_data;
            prev_lane  = sif.out_lane;
            prev_last  = sif.out_last;
            if (sif.in_valid && sif.in_ready) begin
                direct = !(sif.mode == 2'b01 || sif.mode == 2'b10);
                n      = direct ? 1 : ((sif.count == 0) ? L : int'(sif.count));
                start  = direct ? int'(sif.sel) : int'(sif.sel) % L;
                for (int k = 0; k < n; k++) begin
                    if (direct)                 lane = start;
                    else if (sif.mode == 2'b01) lane = (start + k) % L;
                    else                        lane = ((start - k) % L + L) % L;
                    e.lane = SW'(lane);
                    e.data = (lane < L) ? sif.in_data[W*(L-1-lane) +: W] : '0;
                    e.last = (k == n - 1);
                    exp_q.push_back(e);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand) sif.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    task automatic fill_pattern();
        for (int p = 0; p < L; p++) sif.in_data[W*p +: W] = 16'h1000 + 16'(p);
    endtask

    task automatic fill_random();
        for (int p = 0; p < L; p++) sif.in_data[W*p +: W] = 16'($urandom);
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic issue(input logic [1:0] m, input logic [SW-1:0] s, input logic [SW:0] c,
                         input bit scramble);
        int   t;
        logic ok;
        sif.in_valid = 1'b1;
        sif.mode     = m;
        sif.sel      = s;
        sif.count    = c;
        t  = 0;
        ok = 1'b0;
        while (!ok && t < 500) begin
            @(negedge clk);
            ok = sif.in_ready;
            t++;
        end
        check_eq("accept_timeout", ok, 1);
        @(posedge clk);
        #1;
        sif.in_valid = 1'b0;
        if (scramble) fill_random();
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((sif.busy || exp_q.size() != 0) && t < 3000) begin
            @(negedge clk);
            #1;
            t++;
        end
        check_eq("drain_queue", exp_q.size(), 0);
        check_eq("drain_busy", sif.busy, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int b0;
        rst          = 1'b1;
        rdy_rand     = 1'b0;
        sif.in_valid = 1'b1;
        sif.mode     = 2'b00;
        sif.sel      = '0;
        sif.count    = '0;
        sif.out_ready = 1'b0;
        fill_pattern();

        // Reset with in_valid asserted
        repeat (2) begin
            @(negedge clk);
            check_eq("rst_in_ready", sif.in_ready, 0);
            check_eq("rst_out_valid", sif.out_valid, 0);
            check_eq("rst_out_data", sif.out_data, 0);
            check_eq("rst_out_lane", sif.out_lane, 0);
            check_eq("rst_out_last", sif.out_last, 0);
            check_eq("rst_busy", sif.busy, 0);
            @(posedge clk);
            #1;
        end
        rst          = 1'b0;
        sif.in_valid = 1'b0;
        @(negedge clk);
        check_eq("post_rst_in_ready", sif.in_ready, 1);
        @(posedge clk);
        #1;

        // Direct, sel=31 -> physical lane 0
        sif.out_ready = 1'b1;
        issue(2'b00, 5'd31, 6'd0, 1'b0);
        @(negedge clk);
        check_eq("direct_valid", sif.out_valid, 1);
        check_eq("direct_data", sif.out_data, 16'h1000);
        check_eq("direct_lane", sif.out_lane, 31);
        check_eq("direct_last", sif.out_last, 1);
        @(negedge clk);
        check_eq("direct_idle_valid", sif.out_valid, 0);
        check_eq("direct_idle_busy", sif.busy, 0);
        @(posedge clk);
        #1;

        // Scan up with wrap
        issue(2'b01, 5'd30, 6'd4, 1'b0);
        @(negedge clk);
        check_eq("scanup_first_data", sif.out_data, 16'h1001);
        check_eq("scanup_first_lane", sif.out_lane, 30);
        wait_idle();

        // Scan down, full length, backpressure at beat 3
        b0 = n_beat;
        issue(2'b10, 5'd2, 6'd0, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        @(posedge clk);
        #1;
        sif.out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_eq("bp_valid", sif.out_valid, 1);
            check_eq("bp_lane", sif.out_lane, 0);
            check_eq("bp_data", sif.out_data, 16'h101F);
            @(posedge clk);
            #1;
        end
        sif.out_ready = 1'b1;
        wait_idle();
        check_eq("bp_beat_count", n_beat - b0, 32);

        // Back-to-back: direct command queued behind a 2-beat scan
        issue(2'b01, 5'd5, 6'd2, 1'b0);
        issue(2'b00, 5'd0, 6'd0, 1'b0);
        @(negedge clk);
        check_eq("b2b_valid", sif.out_valid, 1);
        check_eq("b2b_data", sif.out_data, 16'h101F);
        check_eq("b2b_lane", sif.out_lane, 0);
        wait_idle();

        // Reset in the middle of a scan
        issue(2'b01, 5'd10, 6'd8, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_valid", sif.out_valid, 0);
        check_eq("midrst_busy", sif.busy, 0);
        check_eq("midrst_data", sif.out_data, 0);
        check_eq("midrst_last", sif.out_last, 0);
        @(posedge clk);
        #1;
        issue(2'b00, 5'd7, 6'd0, 1'b0);
        @(negedge clk);
        check_eq("midrst_next_data", sif.out_data, 16'h1018);
        check_eq("midrst_next_lane", sif.out_lane, 7);
        wait_idle();

        // Random commands, random backpressure, data scrambled after each accept
        rdy_rand = 1'b1;
        fill_random();
        for (int i = 0; i < 150; i++) begin
            issue(2'($urandom), 5'($urandom), 6'($urandom_range(0, L)), 1'b1);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        rdy_rand      = 1'b0;
        sif.out_ready = 1'b1;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
